// File: rtl/cmd_seq_pkg.sv
// cmd_seq_pkg
//   Shared definitions for the command sequencer: state encoding,
//   command codes, err_code values and a small sizing helper.
package cmd_seq_pkg;

    // 3-bit state register; codes 5..7 are illegal and trap to S_ERROR.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_RUN   = 3'd2,
        S_DONE  = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    // Command codes; any code above CMD_CLEAR is illegal.
    localparam int unsigned CMD_NOP   = 0;
    localparam int unsigned CMD_ARM   = 1;
    localparam int unsigned CMD_START = 2;
    localparam int unsigned CMD_ABORT = 3;
    localparam int unsigned CMD_CLEAR = 4;

    // err_code values.
    localparam logic [1:0] ERR_NONE          = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL_CMD   = 2'd1;
    localparam logic [1:0] ERR_ILLEGAL_STATE = 2'd2;
    localparam logic [1:0] ERR_RESERVED      = 2'd3;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seq_counter.sv
// seq_counter
//   Down counter shared by the RUN duration and the ARMED idle timeout.
//   Load has priority over decrement; decrement saturates at zero.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset (count -> 0)
//   load      load load_val this cycle
//   load_val  value to load
//   dec       decrement by one (held at zero when already zero)
//   zero      high while the count is zero
module seq_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/cmd_seq_fsm.sv
// cmd_seq_fsm
//   Command-driven sequencer: IDLE -> ARMED -> RUN -> DONE -> IDLE, with an
//   ARMED idle timeout, ABORT, and a sticky ERROR state entered on an
//   illegal command or an illegal state encoding.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   cmd_valid  command present
//   cmd        command code (IN_W bits)
//   cmd_ready  always 1; a command is accepted when cmd_valid is high
//   out        current state code, zero-extended to OUT_W
//   done       high for the single DONE cycle
//   err        high while in ERROR
//   err_code   0 none, 1 illegal command, 2 illegal state encoding
//   tmo        one-cycle pulse on the cycle after an ARMED timeout
module cmd_seq_fsm
    import cmd_seq_pkg::*;
#(
    parameter int IN_W        = 3,
    parameter int OUT_W       = 3,
    parameter int RUN_LEN     = 8,
    parameter int ARM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    input  logic [IN_W-1:0]  cmd,
    output logic             cmd_ready,
    output logic [OUT_W-1:0] out,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code,
    output logic             tmo
);

    localparam int unsigned CNT_MAX = max_u(RUN_LEN, ARM_TIMEOUT);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RUN_LOAD = CNT_W'(RUN_LEN - 1);
    localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(ARM_TIMEOUT - 1);

    state_t           state;
    state_t           nxt_state;
    logic [1:0]       err_code_q;
    logic [1:0]       nxt_err_code;
    logic [OUT_W-1:0] out_q;
    logic             done_q;
    logic             err_q;
    logic             tmo_q;
    logic             tmo_set;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_dec;
    logic             cnt_zero;

    logic             accept;
    logic             cmd_illegal;
    logic             is_arm;
    logic             is_start;
    logic             is_abort;
    logic             is_clear;

    assign cmd_ready = 1'b1;
    assign accept    = cmd_valid && cmd_ready;

    assign cmd_illegal = accept && (cmd > IN_W'(CMD_CLEAR));
    assign is_arm      = accept && (cmd == IN_W'(CMD_ARM));
    assign is_start    = accept && (cmd == IN_W'(CMD_START));
    assign is_abort    = accept && (cmd == IN_W'(CMD_ABORT));
    assign is_clear    = accept && (cmd == IN_W'(CMD_CLEAR));

    seq_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Next-state and counter control. Priority inside each state:
    // illegal command > ABORT/START > counter expiry.
    always_comb begin
        nxt_state    = state;
        nxt_err_code = err_code_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        tmo_set      = 1'b0;

        case (state)
            S_IDLE: begin
                if (cmd_illegal) begin
                    nxt_state    = S_ERROR;
                    nxt_err_code = ERR_ILLEGAL_CMD;
                end else if (is_arm) begin
                    nxt_state    = S_ARMED;
                    cnt_load     = 1'b1;
                    cnt_load_val = TMO_LOAD;
                end
            end

            S_ARMED: begin
                if (cmd_illegal) begin
                    nxt_state    = S_ERROR;
                    nxt_err_code = ERR_ILLEGAL_CMD;
                end else if (is_start) begin
                    nxt_state    = S_RUN;
                    cnt_load     = 1'b1;
                    cnt_load_val = RUN_LOAD;
                end else if (is_abort) begin
                    nxt_state = S_IDLE;
                end else if (accept) begin
                    // Any other accepted command restarts the idle window.
                    cnt_load     = 1'b1;
                    cnt_load_val = TMO_LOAD;
                end else if (cnt_zero) begin
                    nxt_state = S_IDLE;
                    tmo_set   = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end

            S_RUN: begin
                if (cmd_illegal) begin
                    nxt_state    = S_ERROR;
                    nxt_err_code = ERR_ILLEGAL_CMD;
                end else if (is_abort) begin
                    nxt_state = S_IDLE;
                end else if (cnt_zero) begin
                    nxt_state = S_DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end

            S_DONE: begin
                if (cmd_illegal) begin
                    nxt_state    = S_ERROR;
                    nxt_err_code = ERR_ILLEGAL_CMD;
                end else begin
                    nxt_state = S_IDLE;
                end
            end

            S_ERROR: begin
                if (is_clear) begin
                    nxt_state    = S_IDLE;
                    nxt_err_code = ERR_NONE;
                end
            end

            default: begin
                nxt_state    = S_ERROR;
                nxt_err_code = ERR_ILLEGAL_STATE;
            end
        endcase
    end

    // Outputs are registered from the next state so they always match the
    // state register and never reflect an illegal encoding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            err_code_q <= ERR_NONE;
            out_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            state      <= nxt_state;
            err_code_q <= nxt_err_code;
            out_q      <= OUT_W'(nxt_state);
            done_q     <= (nxt_state == S_DONE);
            err_q      <= (nxt_state == S_ERROR);
            tmo_q      <= tmo_set;
        end
    end

    assign out      = out_q;
    assign done     = done_q;
    assign err      = err_q;
    assign err_code = err_code_q;
    assign tmo      = tmo_q;

endmodule

// File: tb/tb_cmd_seq_fsm.sv
// tb_cmd_seq_fsm
//   Directed bench for cmd_seq_fsm with a cycle-level behavioural model
//   checked on every clock, plus literal expectations on key sequences.
module tb_cmd_seq_fsm;
    import cmd_seq_pkg::*;

    localparam int IN_W        = 3;
    localparam int OUT_W       = 3;
    localparam int RUN_LEN     = 8;
    localparam int ARM_TIMEOUT = 16;

    localparam int M_IDLE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_RUN   = 2;
    localparam int M_DONE  = 3;
    localparam int M_ERROR = 4;

    localparam logic [2:0] C_NOP   = 3'd0;
    localparam logic [2:0] C_ARM   = 3'd1;
    localparam logic [2:0] C_START = 3'd2;
    localparam logic [2:0] C_ABORT = 3'd3;
    localparam logic [2:0] C_CLEAR = 3'd4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic [IN_W-1:0]  cmd;
    logic             cmd_ready;
    logic [OUT_W-1:0] out;
    logic             done;
    logic             err;
    logic [1:0]       err_code;
    logic             tmo;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: mode, idle cycles seen in ARMED, cycles spent in RUN.
    int m_mode;
    int m_idle;
    int m_ran;
    int m_ecode;
    int m_tmo;
    int m_corrupt;
    int n;

    cmd_seq_fsm #(
        .IN_W        (IN_W),
        .OUT_W       (OUT_W),
        .RUN_LEN     (RUN_LEN),
        .ARM_TIMEOUT (ARM_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .cmd_ready (cmd_ready),
        .out       (out),
        .done      (done),
        .err       (err),
        .err_code  (err_code),
        .tmo       (tmo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_tests++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        m_mode    = M_IDLE;
        m_idle    = 0;
        m_ran     = 0;
        m_ecode   = 0;
        m_tmo     = 0;
        m_corrupt = 0;
    endtask

    // One rising edge of the reference behaviour, using the inputs held
    // across that edge.
    task automatic model_edge();
        int c;
        c = int'(cmd);
        m_tmo = 0;
        if (m_corrupt != 0) begin
            m_mode    = M_ERROR;
            m_ecode   = 2;
            m_corrupt = 0;
        end else if (m_mode != M_ERROR && cmd_valid && c > 4) begin
            m_mode  = M_ERROR;
            m_ecode = 1;
        end else begin
            case (m_mode)
                M_IDLE: if (cmd_valid && c == 1) begin
                    m_mode = M_ARMED;
                    m_idle = 0;
                end
                M_ARMED: begin
                    if (cmd_valid) begin
                        if (c == 2) begin
                            m_mode = M_RUN;
                            m_ran  = 0;
                        end else if (c == 3) begin
                            m_mode = M_IDLE;
                        end else begin
                            m_idle = 0;
                        end
                    end else begin
                        m_idle++;
                        if (m_idle == ARM_TIMEOUT) begin
                            m_mode = M_IDLE;
                            m_tmo  = 1;
                        end
                    end
                end
                M_RUN: begin
                    if (cmd_valid && c == 3) begin
                        m_mode = M_IDLE;
                    end else begin
                        m_ran++;
                        if (m_ran == RUN_LEN) m_mode = M_DONE;
                    end
                end
                M_DONE: m_mode = M_IDLE;
                default: if (cmd_valid && c == 4) begin
                    m_mode  = M_IDLE;
                    m_ecode = 0;
                end
            endcase
        end
    endtask

    task automatic compare_all();
        chk("cyc_out",       int'(out),       m_mode);
        chk("cyc_done",      int'(done),      (m_mode == M_DONE)  ? 1 : 0);
        chk("cyc_err",       int'(err),       (m_mode == M_ERROR) ? 1 : 0);
        chk("cyc_err_code",  int'(err_code),  m_ecode);
        chk("cyc_tmo",       int'(tmo),       m_tmo);
        chk("cyc_cmd_ready", int'(cmd_ready), 1);
    endtask

    // Called at a falling edge: drive, clock once, model, then compare.
    task automatic step(input logic v, input logic [2:0] c);
        cmd_valid = v;
        cmd       = c;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(1'b0, C_NOP);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd       = C_NOP;
        model_reset();
        #1;
        chk("rst_out",      int'(out),      0);
        chk("rst_done",     int'(done),     0);
        chk("rst_err",      int'(err),      0);
        chk("rst_err_code", int'(err_code), 0);
        chk("rst_tmo",      int'(tmo),      0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // IDLE ignores everything but ARM.
        step(1'b1, C_NOP);
        step(1'b1, C_START);
        step(1'b1, C_ABORT);
        step(1'b1, C_CLEAR);
        chk("idle_ignore", int'(out), 0);

        // ARM, START: 8 RUN cycles, one DONE, then IDLE (ARM in DONE ignored).
        step(1'b1, C_ARM);
        chk("arm_out", int'(out), 1);
        step(1'b1, C_START);
        n = 0;
        while (out == 3'd2 && n < 40) begin
            n++;
            step(1'b0, C_NOP);
        end
        chk("run_cycles", n, 8);
        chk("done_out", int'(out), 3);
        chk("done_pulse", int'(done), 1);
        step(1'b1, C_ARM);
        chk("after_done_out", int'(out), 0);
        chk("after_done_pulse", int'(done), 0);

        // ARMED timeout after 16 idle cycles.
        step(1'b1, C_ARM);
        n = 0;
        while (out == 3'd1 && n < 60) begin
            n++;
            step(1'b0, C_NOP);
        end
        chk("armed_cycles", n, 16);
        chk("tmo_out", int'(out), 0);
        chk("tmo_pulse", int'(tmo), 1);
        step(1'b0, C_NOP);
        chk("tmo_one_cycle", int'(tmo), 0);

        // An accepted NOP in ARMED restarts the idle window.
        step(1'b1, C_ARM);
        idle(10);
        step(1'b1, C_NOP);
        n = 0;
        while (out == 3'd1 && n < 60) begin
            n++;
            step(1'b0, C_NOP);
        end
        chk("armed_restart", n, 16);

        // START on the timeout cycle wins.
        step(1'b1, C_ARM);
        idle(15);
        step(1'b1, C_START);
        chk("start_beats_tmo_out", int'(out), 2);
        chk("start_beats_tmo_tmo", int'(tmo), 0);
        step(1'b1, C_ABORT);
        chk("abort_run_early", int'(out), 0);

        // ABORT in ARMED.
        step(1'b1, C_ARM);
        step(1'b1, C_ABORT);
        chk("abort_armed", int'(out), 0);

        // ABORT on the last RUN cycle: no DONE.
        step(1'b1, C_ARM);
        step(1'b1, C_START);
        idle(7);
        chk("last_run_cycle", int'(out), 2);
        step(1'b1, C_ABORT);
        chk("abort_last_out", int'(out), 0);
        chk("abort_last_done", int'(done), 0);
        idle(2);

        // Illegal command in ARMED; ERROR is sticky until CLEAR.
        step(1'b1, C_ARM);
        step(1'b1, 3'd6);
        chk("ill_out", int'(out), 4);
        chk("ill_err", int'(err), 1);
        chk("ill_code", int'(err_code), 1);
        step(1'b1, C_ARM);
        step(1'b1, C_ABORT);
        step(1'b1, 3'd7);
        chk("err_sticky", int'(out), 4);
        step(1'b1, C_CLEAR);
        chk("clear_out", int'(out), 0);
        chk("clear_err", int'(err), 0);
        chk("clear_code", int'(err_code), 0);

        // Illegal command in IDLE and in RUN.
        step(1'b1, 3'd5);
        chk("ill_idle", int'(err_code), 1);
        step(1'b1, C_CLEAR);
        step(1'b1, C_ARM);
        step(1'b1, C_START);
        idle(3);
        step(1'b1, 3'd7);
        chk("ill_run", int'(out), 4);
        step(1'b1, C_CLEAR);

        // Illegal state encoding.
        step(1'b1, C_ARM);
        cmd_valid = 1'b0;
        cmd       = C_NOP;
        force dut.state = state_t'(3'd7);
        m_corrupt = 1;
        @(posedge clk);
        model_edge();
        #1 release dut.state;
        @(negedge clk);
        compare_all();
        chk("bad_state_out", int'(out), 4);
        chk("bad_state_code", int'(err_code), 2);
        idle(2);
        step(1'b1, C_CLEAR);
        chk("bad_state_clear", int'(out), 0);

        // Reset mid-RUN, then a clean run.
        step(1'b1, C_ARM);
        step(1'b1, C_START);
        idle(3);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("midrun_rst_out", int'(out), 0);
        chk("midrun_rst_done", int'(done), 0);
        chk("midrun_rst_tmo", int'(tmo), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, C_ARM);
        step(1'b1, C_START);
        n = 0;
        while (out == 3'd2 && n < 40) begin
            n++;
            step(1'b0, C_NOP);
        end
        chk("rerun_cycles", n, 8);
        chk("rerun_done", int'(done), 1);
        step(1'b0, C_NOP);
        chk("rerun_idle", int'(out), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
